// File: rtl/uart_ascii_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_ascii_tx
// Purpose  : Sends an endless sweep of printable ASCII codes over an 8N1 UART
//            line. Bit timing comes from an external 10 kHz divided clock that
//            is sampled as data, synchronised, and edge-detected into a
//            one-cycle bit_tick. All FSM state changes happen on bit_tick.
// Revision : 1.0 - initial release
//
// Parameters
//   FIRST_CHAR  first ASCII code of the sweep (default 8'h20)
//   LAST_CHAR   last ASCII code of the sweep  (default 8'h7E), >= FIRST_CHAR
//
// Ports
//   Clock_100MHz  in   system clock, the only clock
//   Reset_n       in   asynchronous active-low reset
//   clock_10KHz   in   divided bit-rate clock, sampled as data
//   Enable        in   level, 1 = keep sending frames
//   TxD           out  registered serial line, idle high
//   Busy          out  high while a frame is on the line
//   Char          out  ASCII code of the current / next frame
//   Frame_done    out  one-cycle pulse at the end of each stop bit
//
// Build option
//   UART_CRLF_EN  when defined, a CR (8'h0D) and LF (8'h0A) frame are sent
//                 after the LAST_CHAR frame before wrapping to FIRST_CHAR.
// ============================================================================
module uart_ascii_tx #(
  parameter logic [7:0] FIRST_CHAR = 8'h20,
  parameter logic [7:0] LAST_CHAR  = 8'h7E
) (
  input  logic       Clock_100MHz,
  input  logic       Reset_n,
  input  logic       clock_10KHz,
  input  logic       Enable,
  output logic       TxD,
  output logic       Busy,
  output logic [7:0] Char,
  output logic       Frame_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_sync1;
  logic       r_sync2;
  logic       r_hist;
  logic [2:0] r_idx;
  logic       r_txd;
  logic       r_busy;
  logic       r_frame_done;
  logic [7:0] r_char;

  logic       w_bit_tick;
  logic [2:0] w_idx_next;
  logic [7:0] w_char_next;

`ifdef UART_CRLF_EN
  // 0 = normal sweep, 1 = CR frame pending/on line, 2 = LF frame on line
  logic [1:0] r_crlf;
  logic [1:0] w_crlf_next;
`endif

  // --------------------------------------------------------------------------
  // Synchroniser + history FF; bit_tick marks a synchronised rising edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= clock_10KHz;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_bit_tick = r_sync2 & ~r_hist;
  assign w_idx_next = r_idx + 3'd1;

  // --------------------------------------------------------------------------
  // Next character in the sweep
  // --------------------------------------------------------------------------
`ifdef UART_CRLF_EN
  always_comb begin
    w_char_next = r_char + 8'd1;
    w_crlf_next = 2'd0;
    case (r_crlf)
      2'd0: begin
        if (r_char == LAST_CHAR) begin
          w_char_next = 8'h0D;
          w_crlf_next = 2'd1;
        end
      end
      2'd1: begin
        w_char_next = 8'h0A;
        w_crlf_next = 2'd2;
      end
      default: begin
        w_char_next = FIRST_CHAR;
        w_crlf_next = 2'd0;
      end
    endcase
  end
`else
  assign w_char_next = (r_char == LAST_CHAR) ? FIRST_CHAR : (r_char + 8'd1);
`endif

  // --------------------------------------------------------------------------
  // Frame FSM. TxD/Busy are loaded with the value belonging to the state being
  // entered, so the line changes on the same edge as the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_txd        <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_char       <= FIRST_CHAR;
`ifdef UART_CRLF_EN
      r_crlf       <= 2'd0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      if (w_bit_tick) begin
        case (r_state)
          S_IDLE: begin
            if (Enable) begin
              r_state <= S_START;
              r_txd   <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          S_START: begin
            r_state <= S_DATA;
            r_idx   <= 3'd0;
            r_txd   <= r_char[0];
          end
          S_DATA: begin
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_idx <= w_idx_next;
              r_txd <= r_char[w_idx_next];
            end
          end
          S_STOP: begin
            r_frame_done <= 1'b1;
            r_char       <= w_char_next;
`ifdef UART_CRLF_EN
            r_crlf       <= w_crlf_next;
`endif
            r_idx        <= 3'd0;
            // Back-to-back frames: go straight to START without an idle bit
            if (Enable) begin
              r_state <= S_START;
              r_txd   <= 1'b0;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_txd   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign TxD        = r_txd;
  assign Busy       = r_busy;
  assign Char       = r_char;
  assign Frame_done = r_frame_done;

endmodule
`default_nettype wire
